// File: rtl/sdfm_comp_gen2.sv
// sdfm_comp_gen2: sigma-delta comparator channel, one instance per channel.
// The modulator bitstream is resampled into SYSCLK, passed through a
// sinc1/sinc2/sinc3/sincfast decimator, and each output sample is compared
// against low/high thresholds, with deglitching and sticky flags.
// Optional build macro: SDFM_COMP_DEGLITCH_EN enables the consecutive-sample
// deglitch counters. Without it, a comparator qualifies on the raw condition.
module sdfm_comp_gen2 #(
  parameter int DW   = 32,
  parameter int DECW = 8,
  parameter int FLTW = 4
) (
  input  logic            SYSCLK,
  input  logic            SYSRSTn,
  input  logic            DSDIN,
  input  logic            SDCLK,
  input  logic            cfg_en,
  input  logic [1:0]      cfg_mod,
  input  logic [3:0]      cfg_div,
  input  logic [DECW-1:0] cfg_dec,
  input  logic [1:0]      cfg_st,
  input  logic            cfg_sen,
  input  logic [DW-1:0]   cfg_ltrd,
  input  logic [DW-1:0]   cfg_htrd,
  input  logic [FLTW-1:0] cfg_flt,
  input  logic            clr_low,
  input  logic            clr_high,
  output logic [DW-1:0]   data_out,
  output logic            data_vld,
  output logic            low_evt,
  output logic            high_evt,
  output logic            low_flag,
  output logic            high_flag
);

  typedef enum logic [1:0] {MOD_RISE, MOD_FALL, MOD_DIV, MOD_ALL} mod_e;
  typedef enum logic [1:0] {ST_FAST, ST_SINC1, ST_SINC2, ST_SINC3} st_e;

  mod_e w_mod;
  st_e  w_st;
  assign w_mod = mod_e'(cfg_mod);
  assign w_st  = st_e'(cfg_st);

  // Synchroniser and strobe state
  logic r_din_s1, r_din_s2, r_bit;
  logic r_clk_s1, r_clk_s2, r_clk_d;
  logic [5:0] r_div_cnt;
  logic [5:0] w_div_term;
  logic w_stb_raw, r_stb;

  // Integrators, decimation and comb state
  logic [DW-1:0]   r_i1, r_i2, r_i3, w_delta;
  logic [DECW-1:0] r_dec_cnt;
  logic            w_dec, r_dec_d;
  logic [DW-1:0]   r_d1, r_d2, r_d3, r_s2_p1, r_s2_p2;
  logic [DW-1:0]   w_x, w_c1, w_c2, w_c3, w_filt;
  logic [DW-1:0]   r_data_out;
  logic            r_vld;

  // Comparator / deglitch / flag state
  logic w_lo, w_hi, w_lo_q_nx, w_hi_q_nx, w_lo_set, w_hi_set;
  logic r_lo_q, r_hi_q, r_lo_evt, r_hi_evt, r_lo_flag, r_hi_flag;

  // Two-flop synchronisers; r_bit aligns the data bit with the registered strobe
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      r_din_s1 <= 1'b0;
      r_din_s2 <= 1'b0;
      r_bit    <= 1'b0;
      r_clk_s1 <= 1'b0;
      r_clk_s2 <= 1'b0;
      r_clk_d  <= 1'b0;
    end else begin
      r_din_s1 <= DSDIN;
      r_din_s2 <= r_din_s1;
      r_bit    <= r_din_s2;
      r_clk_s1 <= SDCLK;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
    end
  end

  // Terminal count 4*cfg_div+3
  assign w_div_term = {cfg_div, 2'b11};

  // Select the raw sample strobe source
  always_comb begin
    w_stb_raw = 1'b0;
    unique case (w_mod)
      MOD_RISE: w_stb_raw = r_clk_s2 & ~r_clk_d;
      MOD_FALL: w_stb_raw = ~r_clk_s2 & r_clk_d;
      MOD_DIV:  w_stb_raw = (r_div_cnt == w_div_term);
      MOD_ALL:  w_stb_raw = 1'b1;
    endcase
  end

  // SYSCLK divider and registered strobe
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      r_div_cnt <= '0;
      r_stb     <= 1'b0;
    end else begin
      r_stb <= cfg_en & w_stb_raw;
      if (!cfg_en || w_mod != MOD_DIV || r_div_cnt >= w_div_term)
        r_div_cnt <= '0;
      else
        r_div_cnt <= r_div_cnt + 6'd1;
    end
  end

  assign w_delta = r_bit ? DW'(1) : (cfg_sen ? {DW{1'b1}} : '0);
  assign w_dec   = r_stb && (r_dec_cnt == cfg_dec);

  // Integrator cascade and decimation counter, advancing on each strobe
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      r_i1      <= '0;
      r_i2      <= '0;
      r_i3      <= '0;
      r_dec_cnt <= '0;
      r_dec_d   <= 1'b0;
    end else if (!cfg_en) begin
      r_i1      <= '0;
      r_i2      <= '0;
      r_i3      <= '0;
      r_dec_cnt <= '0;
      r_dec_d   <= 1'b0;
    end else begin
      r_dec_d <= w_dec;
      if (r_stb) begin
        r_i1      <= r_i1 + w_delta;
        r_i2      <= r_i2 + r_i1;
        r_i3      <= r_i3 + r_i2;
        r_dec_cnt <= w_dec ? '0 : r_dec_cnt + DECW'(1);
      end
    end
  end

  // Comb cascade: shared delay registers, tap chosen by filter type
  always_comb begin
    w_x = r_i2;
    if (w_st == ST_SINC1)      w_x = r_i1;
    else if (w_st == ST_SINC3) w_x = r_i3;
    w_c1 = w_x - r_d1;
    w_c2 = w_c1 - r_d2;
    w_c3 = w_c2 - r_d3;
    w_filt = '0;
    unique case (w_st)
      ST_FAST:  w_filt = w_c2 + r_s2_p2;
      ST_SINC1: w_filt = w_c1;
      ST_SINC2: w_filt = w_c2;
      ST_SINC3: w_filt = w_c3;
    endcase
  end

  // Comb delay line and output register, clocked one cycle after the dec event
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      r_d1       <= '0;
      r_d2       <= '0;
      r_d3       <= '0;
      r_s2_p1    <= '0;
      r_s2_p2    <= '0;
      r_data_out <= '0;
      r_vld      <= 1'b0;
    end else if (!cfg_en) begin
      r_d1       <= '0;
      r_d2       <= '0;
      r_d3       <= '0;
      r_s2_p1    <= '0;
      r_s2_p2    <= '0;
      r_data_out <= '0;
      r_vld      <= 1'b0;
    end else begin
      r_vld <= r_dec_d;
      if (r_dec_d) begin
        r_d1       <= w_x;
        r_d2       <= w_c1;
        r_d3       <= w_c2;
        r_s2_p1    <= w_c2;
        r_s2_p2    <= r_s2_p1;
        r_data_out <= w_filt;
      end
    end
  end

  assign w_lo = cfg_sen ? ($signed(r_data_out) < $signed(cfg_ltrd)) : (r_data_out < cfg_ltrd);
  assign w_hi = cfg_sen ? ($signed(r_data_out) >= $signed(cfg_htrd)) : (r_data_out >= cfg_htrd);

`ifdef SDFM_COMP_DEGLITCH_EN
  logic [FLTW:0] r_lo_cnt, r_hi_cnt, w_lo_cnt_nx, w_hi_cnt_nx, w_flt_tgt;

  assign w_flt_tgt = {1'b0, cfg_flt} + (FLTW+1)'(1);

  // Saturating run-length counts; a false sample always clears
  always_comb begin
    w_lo_cnt_nx = '0;
    w_hi_cnt_nx = '0;
    if (w_lo) w_lo_cnt_nx = (r_lo_cnt >= w_flt_tgt) ? r_lo_cnt : r_lo_cnt + (FLTW+1)'(1);
    if (w_hi) w_hi_cnt_nx = (r_hi_cnt >= w_flt_tgt) ? r_hi_cnt : r_hi_cnt + (FLTW+1)'(1);
    w_lo_q_nx = (w_lo_cnt_nx >= w_flt_tgt);
    w_hi_q_nx = (w_hi_cnt_nx >= w_flt_tgt);
  end

  // Run-length counters advance only on new samples
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      r_lo_cnt <= '0;
      r_hi_cnt <= '0;
    end else if (!cfg_en) begin
      r_lo_cnt <= '0;
      r_hi_cnt <= '0;
    end else if (r_vld) begin
      r_lo_cnt <= w_lo_cnt_nx;
      r_hi_cnt <= w_hi_cnt_nx;
    end
  end
`else
  logic w_unused_flt;
  assign w_unused_flt = ^cfg_flt;
  assign w_lo_q_nx    = w_lo;
  assign w_hi_q_nx    = w_hi;
`endif

  assign w_lo_set = cfg_en & r_vld & w_lo_q_nx & ~r_lo_q;
  assign w_hi_set = cfg_en & r_vld & w_hi_q_nx & ~r_hi_q;

  // Qualified state and entry event pulses
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      r_lo_q   <= 1'b0;
      r_hi_q   <= 1'b0;
      r_lo_evt <= 1'b0;
      r_hi_evt <= 1'b0;
    end else if (!cfg_en) begin
      r_lo_q   <= 1'b0;
      r_hi_q   <= 1'b0;
      r_lo_evt <= 1'b0;
      r_hi_evt <= 1'b0;
    end else begin
      r_lo_evt <= w_lo_set;
      r_hi_evt <= w_hi_set;
      if (r_vld) begin
        r_lo_q <= w_lo_q_nx;
        r_hi_q <= w_hi_q_nx;
      end
    end
  end

  // Sticky flags; the set term spans the decision cycle and the evt cycle so a
  // clear landing on either one loses
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      r_lo_flag <= 1'b0;
      r_hi_flag <= 1'b0;
    end else begin
      r_lo_flag <= w_lo_set | r_lo_evt | (r_lo_flag & ~clr_low);
      r_hi_flag <= w_hi_set | r_hi_evt | (r_hi_flag & ~clr_high);
    end
  end

  assign data_out  = r_data_out;
  assign data_vld  = r_vld;
  assign low_evt   = r_lo_evt;
  assign high_evt  = r_hi_evt;
  assign low_flag  = r_lo_flag;
  assign high_flag = r_hi_flag;

endmodule

// File: tb/tb_sdfm_comp_gen2.sv
// Directed self-checking bench for sdfm_comp_gen2.
module tb_sdfm_comp_gen2;
  localparam int DW   = 32;
  localparam int DECW = 8;
  localparam int FLTW = 4;

  logic            SYSCLK = 1'b0;
  logic            SYSRSTn = 1'b0;
  logic            DSDIN = 1'b0;
  logic            SDCLK = 1'b0;
  logic            cfg_en = 1'b0;
  logic [1:0]      cfg_mod = '0;
  logic [3:0]      cfg_div = '0;
  logic [DECW-1:0] cfg_dec = '0;
  logic [1:0]      cfg_st = '0;
  logic            cfg_sen = 1'b0;
  logic [DW-1:0]   cfg_ltrd = '0;
  logic [DW-1:0]   cfg_htrd = '0;
  logic [FLTW-1:0] cfg_flt = '0;
  logic            clr_low = 1'b0;
  logic            clr_high = 1'b0;
  logic [DW-1:0]   data_out;
  logic            data_vld, low_evt, high_evt, low_flag, high_flag;

  int checks = 0;
  int errors = 0;

  sdfm_comp_gen2 #(.DW(DW), .DECW(DECW), .FLTW(FLTW)) dut (
    .SYSCLK(SYSCLK), .SYSRSTn(SYSRSTn), .DSDIN(DSDIN), .SDCLK(SDCLK),
    .cfg_en(cfg_en), .cfg_mod(cfg_mod), .cfg_div(cfg_div), .cfg_dec(cfg_dec),
    .cfg_st(cfg_st), .cfg_sen(cfg_sen), .cfg_ltrd(cfg_ltrd), .cfg_htrd(cfg_htrd),
    .cfg_flt(cfg_flt), .clr_low(clr_low), .clr_high(clr_high),
    .data_out(data_out), .data_vld(data_vld), .low_evt(low_evt), .high_evt(high_evt),
    .low_flag(low_flag), .high_flag(high_flag)
  );

  always #5 SYSCLK = ~SYSCLK;

  // Free-running cycle count (advances on each rising edge)
  int cyc = 0;
  always @(posedge SYSCLK) cyc <= cyc + 1;

  // Modulator clock: toggles every 4 SYSCLK, period 8 SYSCLK
  int sd_div = 0;
  always @(negedge SYSCLK) begin
    if (sd_div == 3) begin
      sd_div = 0;
      SDCLK  = ~SDCLK;
    end else begin
      sd_div++;
    end
  end

  // Output log: cycle and value of every data_vld, cycle of every evt
  int n_vld = 0, n_lev = 0, n_hev = 0;
  int vld_cyc[1024];
  logic [DW-1:0] vld_dat[1024];
  int hev_cyc[64];
  always @(negedge SYSCLK) begin
    if (data_vld) begin
      if (n_vld < 1024) begin
        vld_cyc[n_vld] = cyc;
        vld_dat[n_vld] = data_out;
      end
      n_vld++;
    end
    if (low_evt) n_lev++;
    if (high_evt) begin
      if (n_hev < 64) hev_cyc[n_hev] = cyc;
      n_hev++;
    end
  end

  task automatic wait_vld(input int target, input int maxcyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxcyc; i++) begin
      @(posedge SYSCLK);
      if (n_vld >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic setup(input logic [1:0] mod, input logic [3:0] div, input logic [7:0] dec,
                       input logic [1:0] st, input logic sen, input logic [31:0] lt,
                       input logic [31:0] ht, input logic [3:0] flt, input logic din);
    @(negedge SYSCLK);
    cfg_en = 1'b0;
    cfg_mod = mod; cfg_div = div; cfg_dec = dec; cfg_st = st; cfg_sen = sen;
    cfg_ltrd = lt; cfg_htrd = ht; cfg_flt = flt; DSDIN = din;
    repeat (5) @(negedge SYSCLK);
    cfg_en = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge SYSCLK);
    checks++;
    if ({data_out, data_vld, low_evt, high_evt, low_flag, high_flag} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {data_out, data_vld, low_evt, high_evt, low_flag, high_flag});
    end
    SYSRSTn = 1'b1;
  endtask

  // Mode 00, OSR 4, sinc1, all ones: 4 per output, one output per 4 SDCLK periods
  task automatic test_mode00_sinc1();
    int base; bit ok;
    setup(2'b00, 4'd0, 8'd3, 2'b01, 1'b0, 32'h0, 32'hFFFF_FFFF, 4'd0, 1'b1);
    base = n_vld;
    wait_vld(base + 3, 400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mode00_timeout: saw %0d vld, need 3", n_vld - base); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (vld_dat[base+i] !== 32'd4) begin
        errors++; $display("FAIL mode00_data[%0d]: got %h, expected %h", i, vld_dat[base+i], 32'd4);
      end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (vld_cyc[base+i] - vld_cyc[base+i-1] !== 32) begin
        errors++; $display("FAIL mode00_spacing[%0d]: got %0d, expected 32", i, vld_cyc[base+i] - vld_cyc[base+i-1]);
      end
    end
  endtask

  // Signed bitstream of zeros: -4 per output, below ltrd=0, one low_evt, sticky flag
  task automatic test_signed_low();
    int base, lbase; bit ok;
    setup(2'b00, 4'd0, 8'd3, 2'b01, 1'b1, 32'h0, 32'h7FFF_FFFF, 4'd0, 1'b0);
    base = n_vld; lbase = n_lev;
    wait_vld(base + 3, 400, ok);
    repeat (3) @(posedge SYSCLK);
    checks++;
    if (!ok) begin errors++; $display("FAIL signed_timeout: saw %0d vld, need 3", n_vld - base); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (vld_dat[base+i] !== 32'hFFFF_FFFC) begin
        errors++; $display("FAIL signed_data[%0d]: got %h, expected %h", i, vld_dat[base+i], 32'hFFFF_FFFC);
      end
    end
    checks++;
    if (n_lev - lbase !== 1) begin errors++; $display("FAIL low_evt_count: got %0d, expected 1", n_lev - lbase); end
    @(negedge SYSCLK);
    checks++;
    if (low_flag !== 1'b1) begin errors++; $display("FAIL low_flag_sticky: got %b, expected 1", low_flag); end
    checks++;
    if (high_flag !== 1'b0) begin errors++; $display("FAIL high_flag_idle: got %b, expected 0", high_flag); end
  endtask

  // sinc3, OSR 4, all ones: settles at 4^3 = 64
  task automatic test_sinc3();
    int base; bit ok;
    setup(2'b11, 4'd0, 8'd3, 2'b11, 1'b0, 32'h0, 32'hFFFF_FFFF, 4'd0, 1'b1);
    base = n_vld;
    wait_vld(base + 6, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL sinc3_timeout: saw %0d vld, need 6", n_vld - base); end
    for (int i = 3; i < 6; i++) begin
      checks++;
      if (vld_dat[base+i] !== 32'd64) begin
        errors++; $display("FAIL sinc3_data[%0d]: got %0d, expected 64", i, vld_dat[base+i]);
      end
    end
    checks++;
    if (vld_cyc[base+4] - vld_cyc[base+3] !== 4) begin
      errors++; $display("FAIL sinc3_spacing: got %0d, expected 4", vld_cyc[base+4] - vld_cyc[base+3]);
    end
  endtask

  // sincfast, OSR 4, all ones: sinc2 settles at 16, so sinc2(n)+sinc2(n-2) = 32
  task automatic test_sincfast();
    int base; bit ok;
    setup(2'b11, 4'd0, 8'd3, 2'b00, 1'b0, 32'h0, 32'hFFFF_FFFF, 4'd0, 1'b1);
    base = n_vld;
    wait_vld(base + 7, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fast_timeout: saw %0d vld, need 7", n_vld - base); end
    for (int i = 5; i < 7; i++) begin
      checks++;
      if (vld_dat[base+i] !== 32'd32) begin
        errors++; $display("FAIL fast_data[%0d]: got %0d, expected 32", i, vld_dat[base+i]);
      end
    end
  endtask

  // htrd=4 on a constant 4: evt one cycle after the qualifying data_vld
  task automatic test_deglitch();
    int base, hbase, exp_cyc; bit ok;
    setup(2'b11, 4'd0, 8'd3, 2'b01, 1'b0, 32'h0, 32'd4, 4'd2, 1'b1);
    base = n_vld; hbase = n_hev;
    wait_vld(base + 5, 200, ok);
    repeat (3) @(posedge SYSCLK);
    checks++;
    if (!ok) begin errors++; $display("FAIL deglitch_timeout: saw %0d vld, need 5", n_vld - base); end
`ifdef SDFM_COMP_DEGLITCH_EN
    exp_cyc = vld_cyc[base+2] + 1;
`else
    exp_cyc = vld_cyc[base] + 1;
`endif
    checks++;
    if (n_hev - hbase !== 1) begin errors++; $display("FAIL high_evt_count: got %0d, expected 1", n_hev - hbase); end
    checks++;
    if (hev_cyc[hbase] !== exp_cyc) begin
      errors++; $display("FAIL high_evt_cycle: got %0d, expected %0d", hev_cyc[hbase], exp_cyc);
    end
    @(negedge SYSCLK);
    checks++;
    if (high_flag !== 1'b1) begin errors++; $display("FAIL high_flag_set: got %b, expected 1", high_flag); end
  endtask

  // Mode 10, cfg_div=1: strobe every 8 cycles; set beats a coincident clear
  task automatic test_mode10_clear();
    int base; bit ok; bit seen;
    @(negedge SYSCLK);
    cfg_en = 1'b0; clr_low = 1'b1; clr_high = 1'b1;
    @(negedge SYSCLK);
    clr_low = 1'b0; clr_high = 1'b0;
    checks++;
    if ({low_flag, high_flag} !== 2'b00) begin
      errors++; $display("FAIL clear_disabled: got %b, expected 00", {low_flag, high_flag});
    end
    setup(2'b10, 4'd1, 8'd0, 2'b01, 1'b0, 32'h0, 32'd1, 4'd0, 1'b1);
    base = n_vld;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge SYSCLK);
      if (high_evt) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mode10_evt_timeout: got 0, expected high_evt"); end
    clr_high = 1'b1;
    @(negedge SYSCLK);
    clr_high = 1'b0;
    checks++;
    if (high_flag !== 1'b1) begin errors++; $display("FAIL set_over_clear: got %b, expected 1", high_flag); end
    clr_high = 1'b1;
    @(negedge SYSCLK);
    clr_high = 1'b0;
    checks++;
    if (high_flag !== 1'b0) begin errors++; $display("FAIL plain_clear: got %b, expected 0", high_flag); end
    wait_vld(base + 4, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mode10_timeout: saw %0d vld, need 4", n_vld - base); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (vld_cyc[base+i] - vld_cyc[base+i-1] !== 8) begin
        errors++; $display("FAIL mode10_spacing[%0d]: got %0d, expected 8", i, vld_cyc[base+i] - vld_cyc[base+i-1]);
      end
      checks++;
      if (vld_dat[base+i] !== 32'd1) begin
        errors++; $display("FAIL mode10_data[%0d]: got %0d, expected 1", i, vld_dat[base+i]);
      end
    end
    @(negedge SYSCLK);
    checks++;
    if (high_flag !== 1'b0) begin errors++; $display("FAIL no_requal: got %b, expected 0", high_flag); end
  endtask

  // Mode 11, OSR 1: data_vld every cycle, each output 1
  task automatic test_back_to_back();
    int base; bit ok;
    setup(2'b11, 4'd0, 8'd0, 2'b01, 1'b0, 32'h0, 32'hFFFF_FFFF, 4'd0, 1'b1);
    base = n_vld;
    wait_vld(base + 6, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout: saw %0d vld, need 6", n_vld - base); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (vld_dat[base+i] !== 32'd1) begin
        errors++; $display("FAIL b2b_data[%0d]: got %0d, expected 1", i, vld_dat[base+i]);
      end
      if (i > 0) begin
        checks++;
        if (vld_cyc[base+i] - vld_cyc[base+i-1] !== 1) begin
          errors++; $display("FAIL b2b_spacing[%0d]: got %0d, expected 1", i, vld_cyc[base+i] - vld_cyc[base+i-1]);
        end
      end
    end
  endtask

  // Reset mid-decimation: outputs clear at once, next output only after a full OSR
  task automatic test_reset_mid();
    int base, c0, nrel; bit ok;
    setup(2'b11, 4'd0, 8'd3, 2'b01, 1'b0, 32'h0, 32'hFFFF_FFFF, 4'd0, 1'b1);
    base = n_vld;
    wait_vld(base + 2, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_timeout: saw %0d vld, need 2", n_vld - base); end
    @(negedge SYSCLK);
    @(negedge SYSCLK);
    SYSRSTn = 1'b0;
    #1;
    checks++;
    if ({data_out, data_vld, low_evt, high_evt, low_flag, high_flag} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got %h, expected 0",
                         {data_out, data_vld, low_evt, high_evt, low_flag, high_flag});
    end
    repeat (2) @(negedge SYSCLK);
    SYSRSTn = 1'b1;
    c0 = cyc;
    nrel = n_vld;
    // Strobe register loads on the first edge after release, strobes occupy
    // cycles 1..4, dec at 4, data_vld at 4+2 = 6
    wait_vld(nrel + 2, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_timeout2: saw %0d vld, need 2", n_vld - nrel); end
    checks++;
    if (vld_cyc[nrel] - c0 !== 6) begin
      errors++; $display("FAIL rstmid_first_vld: got %0d cycles, expected 6", vld_cyc[nrel] - c0);
    end
    checks++;
    if (vld_cyc[nrel+1] - vld_cyc[nrel] !== 4) begin
      errors++; $display("FAIL rstmid_spacing: got %0d, expected 4", vld_cyc[nrel+1] - vld_cyc[nrel]);
    end
    checks++;
    if (vld_dat[nrel+1] !== 32'd4) begin
      errors++; $display("FAIL rstmid_data: got %0d, expected 4", vld_dat[nrel+1]);
    end
  endtask

  initial begin
    repeat (3) @(negedge SYSCLK);
    test_reset();
    test_mode00_sinc1();
    test_signed_low();
    test_sinc3();
    test_sincfast();
    test_deglitch();
    test_mode10_clear();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdfm_comp_gen2.md
# sdfm_comp_gen2

Second-generation sigma-delta comparator channel. Per channel it:
- resamples one modulator bitstream into the SYSCLK domain;
- runs a selectable sinc1/sinc2/sinc3/sincfast filter with a programmable oversampling ratio;
- compares each decimated sample against low and high thresholds, with consecutive-sample deglitching and sticky flags.

It is fully synchronous to SYSCLK: there are no derived or gated clocks. It sits between the SDFM pin interface and the interrupt/register block, one instance per channel.

## Interface
- DW, 32, filter datapath and threshold width (≥ 16)
- DECW, 8, decimation counter width
- FLTW, 4, deglitch count width
- SYSCLK  in  1  system clock
- SYSRSTn  in  1  asynchronous active-low reset
- DSDIN  in  1  modulator bitstream (asynchronous)
- SDCLK  in  1  modulator clock (asynchronous)
- cfg_en  in  1  channel enable
- cfg_mod  in  2  sample strobe source: 00 SDCLK rise, 01 SDCLK fall, 10 divided SYSCLK, 11 every SYSCLK
- cfg_div  in  4  divider for mode 10
- cfg_dec  in  DECW  OSR−1
- cfg_st  in  2  filter: 00 sincfast, 01 sinc1, 10 sinc2, 11 sinc3
- cfg_sen  in  1  signed bitstream (0 → −1) and signed compares
- cfg_ltrd  in  DW  low threshold
- cfg_htrd  in  DW  high threshold
- cfg_flt  in  FLTW  deglitch: consecutive qualifying samples − 1
- clr_low, clr_high  in  1  one-cycle sticky-flag clear pulses
- data_out  out  DW  filtered sample (registered)
- data_vld  out  1  one-cycle pulse per new data_out
- low_evt, high_evt  out  1  one-cycle pulse on qualified threshold entry
- low_flag, high_flag  out  1  sticky flags

Reset: SYSRSTn, asynchronous, active-low; clock SYSCLK. All outputs and all internal state are reset to 0.

## Operation
- Input sync:
  - DSDIN and SDCLK each pass through a 2-FF synchroniser.
  - Modes 00/01 detect edges on the synchronised SDCLK.
  - Mode 10: a counter runs 0..4·cfg_div+3 and strobes at its terminal count, giving a period of 4·cfg_div+4 cycles.
  - Mode 11: strobe every cycle.
- Integrators I1..I3 are DW bits wide, wrap modulo 2^DW, and update only on a strobe.
  - I1 += 1 when the bit is 1.
  - When the bit is 0: I1 += −1 if cfg_sen, else I1 += 0.
  - I2 += I1; I3 += I2.
- Decimation counter:
  - Counts strobes 0..cfg_dec; OSR = cfg_dec+1.
  - A strobe while count==cfg_dec produces the dec event and resets the count to 0.
  - cfg_dec=0 gives one output per strobe.
- Combs, clocked on the dec event (registered one cycle later):
  - Integrator selection: sinc1 uses I1, sinc2/sincfast use I2, sinc3 uses I3.
  - Cascade: sinc1 uses 1 comb, sinc2 uses 2, sinc3 uses 3.
  - sincfast output = sinc2(n) + sinc2(n−2).
- Compare on each data_vld:
  - lo = data_out < cfg_ltrd; hi = data_out ≥ cfg_htrd.
  - Compares are signed if cfg_sen, else unsigned.
- Deglitch, per comparator:
  - A saturating counter increments on each data_vld with the condition true and clears on data_vld with it false.
  - Qualified when the counter reaches cfg_flt+1.
  - evt pulses once on entry into qualified; requalification requires a false sample first.
- Sticky flags:
  - Set by evt, cleared by clr_*.
  - Set wins over a simultaneous clear.
- cfg_en=0:
  - Synchronously clears integrators, combs, counters, deglitch state and data_out.
  - Suppresses data_vld and evt.
  - Flags keep their value and stay clearable.
- Config changes take effect on the next strobe; there is no shadowing.

## Timing
- Pin SDCLK edge → strobe: 3 SYSCLK (2 sync + edge detect).
- Minimum input spacing:
  - Modes 00/01 require SDCLK high and low each ≥ 2 SYSCLK; narrower pulses may be lost.
  - Each SDCLK period yields exactly one strobe.
- Dec strobe at cycle T:
  - Integrators update at the end of T.
  - Combs capture at T+1.
  - data_out updates and data_vld=1 at T+2.
  - evt and flag set at T+3.
- Back-to-back outputs (mode 11, cfg_dec=0): data_vld may be high every cycle, and throughput is sustained.
- Reset mid-operation: everything returns to 0 immediately, with no partial output.

## Configuration
- SDFM_COMP_DEGLITCH_EN defined: deglitch counters are present as described.
- Not defined:
  - cfg_flt is ignored and counters are removed.
  - Qualified = raw condition at each data_vld.
  - evt pulses on each false→true transition.

## Test plan
- Mode 00, cfg_dec=3, sinc1, cfg_sen=0, DSDIN=1: every data_out=4; data_vld every 4 SDCLK periods.
- Same setup, cfg_sen=1, DSDIN=0: data_out=0xFFFF_FFFC; with cfg_ltrd=0, low_evt fires once and low_flag stays set.
- sinc3, cfg_dec=3, DSDIN=1: output settles at 64 from the fourth data_vld onward.
- sinc1, cfg_htrd=4, cfg_flt=2: high_evt is asserted on the third data_vld, 1 cycle after it; with the macro undefined, it is asserted 1 cycle after the first data_vld.
- Mode 10, cfg_div=1: strobe every 8 SYSCLK; clr_high coincident with high_evt leaves high_flag=1.
- Assert SYSRSTn low mid-decimation, then release: all outputs 0; the first data_vld comes after a full OSR of strobes.
